cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Round-robin arbiter that shares the single Common Data Bus (CDB) among NUM_REQ completing functional units (ALU, MULT, LD, BR).
- The winner's completion record is registered and driven as the CDB packet. The ROB consumes it to set cp/ep bits, value and NPC; RS and map table snoop it for wakeup.
- One grant per cycle. Losers hold their request until granted.

Parameters:
- NUM_REQ, 4, number of requesting functional units (2..8; need not be a power of two).
- TAG_W, 5, ROB tag width (= $clog2 of ROB size 32).
- XLEN, 32, width of value and NPC.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  pipeline advance. Low freezes arbiter state and output.
- squash_signal  in  1  branch-mispredict flush.
- fu_req  in  NUM_REQ  per-FU completion request, held until granted.
- fu_tag  in  NUM_REQ*TAG_W  per-FU ROB tag.
- fu_value  in  NUM_REQ*XLEN  per-FU result value.
- fu_npc  in  NUM_REQ*XLEN  per-FU next PC.
- fu_take_branch  in  NUM_REQ  per-FU branch-taken flag.
- fu_gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as request.
- cdb_valid  out  1  registered CDB valid.
- cdb_tag  out  TAG_W  registered ROB tag.
- cdb_value  out  XLEN  registered value.
- cdb_npc  out  XLEN  registered next PC.
- cdb_take_branch  out  1  registered branch-taken flag.

Behaviour:
- State: priority pointer ptr (range 0..NUM_REQ-1) plus the CDB output registers.
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - ptr=0.
  - All cdb_* outputs = 0.
  - fu_gnt reads 0 while reset is high.
- Arbitration is combinational when enable=1 and squash_signal=0:
  - Scan indices ptr, ptr+1, ..., wrapping modulo NUM_REQ. The first index i with fu_req[i]=1 wins.
  - fu_gnt = one-hot(i), or 0 if no request.
- Non-power-of-two NUM_REQ: wrap is an explicit compare to NUM_REQ-1, never bit truncation.
- Posedge with enable=1, squash_signal=0, winner i:
  - cdb_valid<=1; cdb_tag/value/npc/take_branch<=FU i fields.
  - ptr<=(i==NUM_REQ-1)?0:i+1.
- Posedge with enable=1, squash_signal=0, no request: cdb_valid<=0, other cdb fields hold, ptr holds.
- Latency: request in cycle N; grant in cycle N; CDB visible in cycle N+1.
- A granted FU deasserts or replaces its request in cycle N+1. An ungranted FU keeps request and fields stable.
- enable=0: fu_gnt=0; ptr and all cdb_* registers hold. A valid CDB packet stays on the bus, so the ROB, which is also frozen, sees it exactly once.
- squash_signal=1 (has priority over enable): fu_gnt=0; at posedge cdb_valid<=0 and ptr<=0.
- Simultaneous squash and reset: reset wins.
- Fairness: with all FUs continuously requesting, each is granted exactly once every NUM_REQ cycles.

Optional Feature:
- Macro: CDB_ARB_STATS_EN.
- Defined:
  - Adds output grant_cnt (NUM_REQ*16), per-FU saturating 16-bit grant counters, incremented at every posedge where that FU is granted.
  - Adds output conflict_cnt (16), saturating, incremented each arbitrated cycle with two or more requests.
  - Both counters are cleared by reset only, not by squash, and hold when enable=0.
- Undefined: no counters, no extra ports, behaviour otherwise identical.

Decomposition:
- Shared package (sys_defs): CDB_PACKET typedef (valid, Tag, Value, NPC, take_branch); FU_CDB_REQ typedef (req, tag, value, npc, take_branch); constants NUM_FU_CDB and ROB tag width.
- Ports may be packed arrays of FU_CDB_REQ and a CDB_PACKET output, with field widths matching this list.
- One sub-module: rr_pick, purely combinational. Inputs: request vector, ptr. Outputs: one-hot grant, winner index, any_req. Reusable for issue select.

Test Plan:
- Reset then idle → fu_gnt=0, cdb_valid=0, ptr=0. Assert reset mid-stream while cdb_valid=1 → cdb_valid drops without a clock edge.
- Single requester FU2 with ptr=0, tag=7, value=0xDEAD_BEEF, npc=0x104 → fu_gnt=4'b0100 same cycle. Next cycle cdb_valid=1, tag=7, value=0xDEADBEEF, npc=0x104, ptr=3.
- All four FUs requesting continuously for 8 cycles from ptr=0 → grant order 0,1,2,3,0,1,2,3. Each FU has two CDB packets.
- FU3 and FU1 requesting, ptr=2 → FU3 granted first, ptr wraps to 0. FU1 granted next cycle, ptr=2.
- Packet pending on CDB; enable=0 for 3 cycles with FU0 requesting → fu_gnt=0, CDB fields unchanged. After enable=1, FU0 granted.
- squash_signal=1 with FU1 and FU2 requesting → fu_gnt=0, next cycle cdb_valid=0, ptr=0. With CDB_ARB_STATS_EN, the scenario 3 run gives grant_cnt=2 per FU and conflict_cnt=8.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter_pkg
//  Description : Shared definitions for the Common Data Bus arbiter. Holds
//                the default FU count and field widths, the CDB packet and
//                FU completion-request record types, and a small helper used
//                to detect bus contention.
//  Revision    : 1.0 - initial release
// ============================================================================
package cdb_arbiter_pkg;

    // Default number of functional units competing for the CDB
    // (ALU, MULT, LD, BR).
    localparam int NUM_FU_CDB = 4;

    // ROB tag width: a 32-entry ROB needs 5 tag bits.
    localparam int ROB_TAG_W  = 5;

    // Width of the result value and the next PC.
    localparam int CDB_XLEN   = 32;

    // Packet broadcast on the CDB. The ROB uses it to set the complete and
    // exception bits, value and NPC. RS and the map table snoop the tag.
    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] tag;
        logic [CDB_XLEN-1:0]  value;
        logic [CDB_XLEN-1:0]  npc;
        logic                 take_branch;
    } CDB_PACKET;

    // Completion record presented by one functional unit.
    typedef struct packed {
        logic                 req;
        logic [ROB_TAG_W-1:0] tag;
        logic [CDB_XLEN-1:0]  value;
        logic [CDB_XLEN-1:0]  npc;
        logic                 take_branch;
    } FU_CDB_REQ;

    // True when two or more bits of v are set. Clearing the lowest set bit
    // leaves a non-zero value only if another bit was also set.
    function automatic logic at_least_two(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

endpackage : cdb_arbiter_pkg
`default_nettype wire

// File: rtl/cdb_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector. Scans the request vector
//                starting at ptr and wrapping modulo N. The first set request
//                wins. Reusable for any rotating-priority select, for example
//                issue select.
//  Ports       : req     [N]     request vector
//                ptr     [PTR_W] index that has highest priority this cycle
//                gnt     [N]     one-hot grant, zero when nothing requests
//                idx     [PTR_W] index of the winner, zero when nothing requests
//                any_req         at least one request is present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] idx,
    output logic             any_req
);

    // One extra bit so that ptr + offset never overflows before the wrap.
    logic [PTR_W:0] w_cand;

    always_comb begin
        gnt     = '0;
        idx     = '0;
        any_req = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = {1'b0, ptr} + (PTR_W+1)'(k);
            // Wrap with an explicit compare. Dropping the top bit would be
            // wrong when N is not a power of two.
            if (w_cand > (PTR_W+1)'(N - 1)) begin
                w_cand = w_cand - (PTR_W+1)'(N);
            end
            if (!any_req && req[w_cand[PTR_W-1:0]]) begin
                any_req                = 1'b1;
                gnt[w_cand[PTR_W-1:0]] = 1'b1;
                idx                    = w_cand[PTR_W-1:0];
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Round-robin arbiter for the single Common Data Bus. The grant
//                is combinational in the request cycle. The winner's
//                completion record is registered and appears on the CDB in the
//                following cycle. Losing units hold their request until they
//                are granted.
//  Ports       : clock, reset (async, active high)
//                enable          pipeline advance; low freezes state and bus
//                squash_signal   mispredict flush; drops the bus, resets ptr
//                fu_req/tag/value/npc/take_branch  per-FU completion records
//                fu_gnt          one-hot grant (combinational)
//                cdb_valid/tag/value/npc/take_branch  registered CDB packet
//  Options     : CDB_ARB_STATS_EN adds grant_cnt (16 bits per FU) and
//                conflict_cnt (16 bits). Both are saturating statistics
//                counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_FU_CDB,
    parameter int TAG_W   = ROB_TAG_W,
    parameter int XLEN    = CDB_XLEN
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     squash_signal,
    input  logic [NUM_REQ-1:0]       fu_req,
    input  logic [NUM_REQ*TAG_W-1:0] fu_tag,
    input  logic [NUM_REQ*XLEN-1:0]  fu_value,
    input  logic [NUM_REQ*XLEN-1:0]  fu_npc,
    input  logic [NUM_REQ-1:0]       fu_take_branch,
    output logic [NUM_REQ-1:0]       fu_gnt,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [XLEN-1:0]          cdb_value,
    output logic [XLEN-1:0]          cdb_npc,
    output logic                     cdb_take_branch
`ifdef CDB_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]    grant_cnt,
    output logic [15:0]              conflict_cnt
`endif
);

    localparam int c_PTR_W = $clog2(NUM_REQ);

    logic [c_PTR_W-1:0] r_ptr;

    logic               w_arb_en;
    logic [NUM_REQ-1:0] w_pick_gnt;
    logic [c_PTR_W-1:0] w_pick_idx;
    logic               w_pick_any;
    logic [c_PTR_W-1:0] w_ptr_next;
    logic [TAG_W-1:0]   w_win_tag;
    logic [XLEN-1:0]    w_win_value;
    logic [XLEN-1:0]    w_win_npc;
    logic               w_win_tb;

    // Squash overrides enable. Arbitration runs only in an advancing,
    // unsquashed cycle.
    assign w_arb_en = enable & ~squash_signal;

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (c_PTR_W)
    ) u_rr_pick (
        .req     (fu_req),
        .ptr     (r_ptr),
        .gnt     (w_pick_gnt),
        .idx     (w_pick_idx),
        .any_req (w_pick_any)
    );

    // No FU may see a grant while reset is high. Otherwise it would retire
    // a request that never reaches the bus.
    assign fu_gnt = (w_arb_en && !reset) ? w_pick_gnt : '0;

    // Priority moves to the unit just after the winner, wrapping by compare.
    assign w_ptr_next = (w_pick_idx == c_PTR_W'(NUM_REQ - 1)) ? '0
                                                            : w_pick_idx + c_PTR_W'(1);

    assign w_win_tag   = fu_tag  [w_pick_idx*TAG_W +: TAG_W];
    assign w_win_value = fu_value[w_pick_idx*XLEN  +: XLEN];
    assign w_win_npc   = fu_npc  [w_pick_idx*XLEN  +: XLEN];
    assign w_win_tb    = fu_take_branch[w_pick_idx];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr           <= '0;
            cdb_valid       <= 1'b0;
            cdb_tag         <= '0;
            cdb_value       <= '0;
            cdb_npc         <= '0;
            cdb_take_branch <= 1'b0;
        end else if (squash_signal) begin
            cdb_valid <= 1'b0;
            r_ptr     <= '0;
        end else if (enable) begin
            if (w_pick_any) begin
                cdb_valid       <= 1'b1;
                cdb_tag         <= w_win_tag;
                cdb_value       <= w_win_value;
                cdb_npc         <= w_win_npc;
                cdb_take_branch <= w_win_tb;
                r_ptr           <= w_ptr_next;
            end else begin
                // Idle cycle: the payload fields keep their stale data.
                // Only valid drops.
                cdb_valid <= 1'b0;
            end
        end
        // enable low: everything holds. A pending packet stays on the bus
        // for the frozen ROB.
    end

`ifdef CDB_ARB_STATS_EN
    logic [15:0] r_conflict_cnt;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_grant_cnt
        logic [15:0] r_cnt;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_cnt <= '0;
            end else if (fu_gnt[g] && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end

        assign grant_cnt[g*16 +: 16] = r_cnt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_conflict_cnt <= '0;
        end else if (w_arb_en && at_least_two(8'(fu_req)) && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule : cdb_arbiter
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdb_arbiter
//  Description : Self-checking bench for cdb_arbiter. A directed vector table
//                covers rotation, wrap, idle, enable-freeze and squash. Short
//                hand-written sequences cover the single-requester packet,
//                the multi-cycle enable hold and an asynchronous reset
//                mid-stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TAG_W   = 5;
    localparam int XLEN    = 32;
    localparam int c_NVEC  = 21;

    logic                     clock;
    logic                     reset;
    logic                     enable;
    logic                     squash_signal;
    logic [NUM_REQ-1:0]       fu_req;
    logic [NUM_REQ*TAG_W-1:0] fu_tag;
    logic [NUM_REQ*XLEN-1:0]  fu_value;
    logic [NUM_REQ*XLEN-1:0]  fu_npc;
    logic [NUM_REQ-1:0]       fu_take_branch;
    logic [NUM_REQ-1:0]       fu_gnt;
    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_tag;
    logic [XLEN-1:0]          cdb_value;
    logic [XLEN-1:0]          cdb_npc;
    logic                     cdb_take_branch;
`ifdef CDB_ARB_STATS_EN
    logic [NUM_REQ*16-1:0]    grant_cnt;
    logic [15:0]              conflict_cnt;
`endif

    cdb_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TAG_W   (TAG_W),
        .XLEN    (XLEN)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .squash_signal   (squash_signal),
        .fu_req          (fu_req),
        .fu_tag          (fu_tag),
        .fu_value        (fu_value),
        .fu_npc          (fu_npc),
        .fu_take_branch  (fu_take_branch),
        .fu_gnt          (fu_gnt),
        .cdb_valid       (cdb_valid),
        .cdb_tag         (cdb_tag),
        .cdb_value       (cdb_value),
        .cdb_npc         (cdb_npc),
        .cdb_take_branch (cdb_take_branch)
`ifdef CDB_ARB_STATS_EN
        ,
        .grant_cnt       (grant_cnt),
        .conflict_cnt    (conflict_cnt)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int idx, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h", nm, idx, act, exp);
        end
    endtask

    // Each FU carries a distinct record that changes per vector, so the
    // bench can tell whose data reached the bus.
    function automatic logic [TAG_W-1:0] ftag(input int f, input int n);
        return TAG_W'((n * 4 + f) % 32);
    endfunction
    function automatic logic [XLEN-1:0] fval(input int f, input int n);
        return 32'hA000_0000 | 32'(n << 8) | 32'(f);
    endfunction
    function automatic logic [XLEN-1:0] fnpc(input int f, input int n);
        return 32'(32'h1000 + n * 16 + f * 4);
    endfunction
    function automatic logic ftb(input int f, input int n);
        return 1'((n + f) % 2);
    endfunction

    typedef struct {
        logic       en;
        logic       sq;
        logic [3:0] req;
        logic [3:0] gnt;    // expected combinational grant
        int         win;    // expected winner, -1 for none
        int         ptr;    // expected priority pointer after the edge
    } vec_t;

    vec_t vt [c_NVEC];

    // Bench-side expectation of the bus registers.
    logic             e_valid;
    logic [TAG_W-1:0] e_tag;
    logic [XLEN-1:0]  e_value;
    logic [XLEN-1:0]  e_npc;
    logic             e_tb;

    initial begin
        //            en    sq    req      gnt      win ptr
        vt[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, -1, 0}; // idle after reset
        vt[1]  = '{1'b1, 1'b0, 4'b1111, 4'b0001,  0, 1}; // all request
        vt[2]  = '{1'b1, 1'b0, 4'b1111, 4'b0010,  1, 2};
        vt[3]  = '{1'b1, 1'b0, 4'b1111, 4'b0100,  2, 3};
        vt[4]  = '{1'b1, 1'b0, 4'b1111, 4'b1000,  3, 0};
        vt[5]  = '{1'b1, 1'b0, 4'b1111, 4'b0001,  0, 1};
        vt[6]  = '{1'b1, 1'b0, 4'b1111, 4'b0010,  1, 2};
        vt[7]  = '{1'b1, 1'b0, 4'b1111, 4'b0100,  2, 3};
        vt[8]  = '{1'b1, 1'b0, 4'b1111, 4'b1000,  3, 0};
        vt[9]  = '{1'b1, 1'b0, 4'b0010, 4'b0010,  1, 2}; // ptr -> 2
        vt[10] = '{1'b1, 1'b0, 4'b1010, 4'b1000,  3, 0}; // FU3 before FU1, wrap
        vt[11] = '{1'b1, 1'b0, 4'b0010, 4'b0010,  1, 2};
        vt[12] = '{1'b1, 1'b0, 4'b0000, 4'b0000, -1, 2}; // idle, ptr holds
        vt[13] = '{1'b0, 1'b0, 4'b0001, 4'b0000, -1, 2}; // frozen
        vt[14] = '{1'b1, 1'b1, 4'b0001, 4'b0000, -1, 0}; // squash from ptr 2
        vt[15] = '{1'b1, 1'b0, 4'b0110, 4'b0010,  1, 2};
        vt[16] = '{1'b1, 1'b1, 4'b0110, 4'b0000, -1, 0}; // squash with FU1,FU2
        vt[17] = '{1'b1, 1'b0, 4'b0100, 4'b0100,  2, 3};
        vt[18] = '{1'b0, 1'b1, 4'b1000, 4'b0000, -1, 0}; // squash beats enable=0
        vt[19] = '{1'b1, 1'b0, 4'b1001, 4'b0001,  0, 1};
        vt[20] = '{1'b1, 1'b0, 4'b1000, 4'b1000,  3, 0}; // scan 1,2,3
    end

    task automatic drive_fields(input int n);
        for (int f = 0; f < NUM_REQ; f++) begin
            fu_tag[f*TAG_W +: TAG_W] = ftag(f, n);
            fu_value[f*XLEN +: XLEN] = fval(f, n);
            fu_npc[f*XLEN +: XLEN]   = fnpc(f, n);
            fu_take_branch[f]        = ftb(f, n);
        end
    endtask

    task automatic chk_bus(input string nm, input int idx);
        chk({nm, "_valid"}, idx, 128'(cdb_valid), 128'(e_valid));
        chk({nm, "_pkt"}, idx, 128'({cdb_tag, cdb_value, cdb_npc, cdb_take_branch}),
            128'({e_tag, e_value, e_npc, e_tb}));
    endtask

    initial begin
        reset          = 1'b1;
        enable         = 1'b1;
        squash_signal  = 1'b0;
        fu_req         = 4'b1111;
        fu_tag         = '0;
        fu_value       = '0;
        fu_npc         = '0;
        fu_take_branch = '0;
        e_valid = 1'b0; e_tag = '0; e_value = '0; e_npc = '0; e_tb = 1'b0;

        // Reset state, with requests present to show the grant is masked.
        repeat (2) @(posedge clock);
        #1;
        chk("rst_gnt", 0, 128'(fu_gnt), 128'(0));
        chk("rst_ptr", 0, 128'(dut.r_ptr), 128'(0));
        chk_bus("rst", 0);
        @(negedge clock);
        fu_req = '0;
        reset  = 1'b0;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < c_NVEC; i++) begin
            @(negedge clock);
            enable        = vt[i].en;
            squash_signal = vt[i].sq;
            fu_req        = vt[i].req;
            drive_fields(i);
            #1;
            chk("gnt", i, 128'(fu_gnt), 128'(vt[i].gnt));
            if (vt[i].sq) begin
                e_valid = 1'b0;
            end else if (vt[i].en) begin
                if (vt[i].win >= 0) begin
                    e_valid = 1'b1;
                    e_tag   = ftag(vt[i].win, i);
                    e_value = fval(vt[i].win, i);
                    e_npc   = fnpc(vt[i].win, i);
                    e_tb    = ftb(vt[i].win, i);
                end else begin
                    e_valid = 1'b0;
                end
            end
            @(posedge clock);
            #1;
            chk_bus("cdb", i);
            chk("ptr", i, 128'(dut.r_ptr), 128'(vt[i].ptr));
`ifdef CDB_ARB_STATS_EN
            if (i == 8) begin
                for (int f = 0; f < NUM_REQ; f++) begin
                    chk("grant_cnt", f, 128'(grant_cnt[f*16 +: 16]), 128'(2));
                end
                chk("conflict_cnt", 0, 128'(conflict_cnt), 128'(8));
            end
`endif
        end

        // ---------------- single requester FU2 from ptr 0 ----------------
        @(negedge clock);
        enable = 1'b1; squash_signal = 1'b0;
        fu_req = 4'b0100;
        fu_tag[2*TAG_W +: TAG_W] = 5'd7;
        fu_value[2*XLEN +: XLEN] = 32'hDEAD_BEEF;
        fu_npc[2*XLEN +: XLEN]   = 32'h0000_0104;
        fu_take_branch[2]        = 1'b1;
        #1;
        chk("fu2_gnt", 0, 128'(fu_gnt), 128'(4'b0100));
        @(posedge clock);
        #1;
        e_valid = 1'b1; e_tag = 5'd7; e_value = 32'hDEAD_BEEF; e_npc = 32'h104; e_tb = 1'b1;
        chk_bus("fu2", 0);
        chk("fu2_ptr", 0, 128'(dut.r_ptr), 128'(3));

        // ---------------- enable low for 3 cycles with a pending packet ----------------
        @(negedge clock);
        enable = 1'b0;
        fu_req = 4'b0001;
        fu_tag[0 +: TAG_W]    = 5'd3;
        fu_value[0 +: XLEN]   = 32'h5555_0000;
        fu_npc[0 +: XLEN]     = 32'h0000_0200;
        fu_take_branch[0]     = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("hold_gnt", c, 128'(fu_gnt), 128'(0));
            @(posedge clock);
            #1;
            chk_bus("hold", c);
            chk("hold_ptr", c, 128'(dut.r_ptr), 128'(3));
            @(negedge clock);
        end
        enable = 1'b1;
        #1;
        chk("resume_gnt", 0, 128'(fu_gnt), 128'(4'b0001));
        @(posedge clock);
        #1;
        e_valid = 1'b1; e_tag = 5'd3; e_value = 32'h5555_0000; e_npc = 32'h200; e_tb = 1'b0;
        chk_bus("resume", 0);
        chk("resume_ptr", 0, 128'(dut.r_ptr), 128'(1));

        // ---------------- asynchronous reset while the bus is valid ----------------
        @(negedge clock);
        #2;
        chk("pre_rst_valid", 0, 128'(cdb_valid), 128'(1));
        reset = 1'b1;
        #1;
        // Still before the next rising edge: the reset alone must clear state.
        e_valid = 1'b0; e_tag = '0; e_value = '0; e_npc = '0; e_tb = 1'b0;
        chk_bus("arst", 0);
        chk("arst_ptr", 0, 128'(dut.r_ptr), 128'(0));
        chk("arst_gnt", 0, 128'(fu_gnt), 128'(0));
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("post_rst_gnt", 0, 128'(fu_gnt), 128'(4'b0001));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_cdb_arbiter
`default_nettype wire
